// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, source tags, parameter defaults and the write payload type
// for the register-file write arbiter.
package regfile_write_arbiter_pkg;

   localparam int unsigned RegNumWidth = 5;
   localparam int unsigned DataWidth   = 32;
   localparam int unsigned NumRegs     = 32;

   // Source tag carried alongside a write when tracing is enabled
   localparam logic SRC_WB  = 1'b0;
   localparam logic SRC_MDU = 1'b1;

   localparam int unsigned FIFO_DEPTH_DEFAULT   = 2;
   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

   typedef struct packed {
      logic [RegNumWidth-1:0] num;
      logic [DataWidth-1:0]   data;
   } rf_wr_t;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// regarb_fifo: synchronous FIFO buffering MDU results ({num, data}) until
// they win the register-file write port. DEPTH must be a power of two so
// the pointers wrap naturally.
module regarb_fifo
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  rf_wr_t          push_entry,
   input  logic            pop,
   output rf_wr_t          head,
   output logic [CntW-1:0] count,
   output logic            full,
   output logic            empty
);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   rf_wr_t          mem_q [DEPTH];
   rf_wr_t          mem_d [DEPTH];
   logic            do_push;
   logic            do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next pointers, occupancy and storage contents
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Control state; reset empties the FIFO
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while counted valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the register file's single write port, sharing
// it between the WB stage and buffered MDU results, with a starvation guard
// for the MDU side and a per-register busy scoreboard for decode hazards.
// Optional trace output: define REGARB_TRACE_EN.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wbValid,
   input  logic [RegNumWidth-1:0] wbNum,
   input  logic [DataWidth-1:0]   wbData,
   output logic                   wbStall,
   input  logic                   mduIssue,
   input  logic [RegNumWidth-1:0] mduIssueNum,
   input  logic                   mduValid,
   output logic                   mduReady,
   input  logic [RegNumWidth-1:0] mduNum,
   input  logic [DataWidth-1:0]   mduData,
   input  logic [RegNumWidth-1:0] regNum0,
   input  logic [RegNumWidth-1:0] regNum1,
   output logic                   hazard0,
   output logic                   hazard1,
   output logic                   regWriteEnable,
   output logic [RegNumWidth-1:0] regWriteNum,
   output logic [DataWidth-1:0]   regWriteData,
   output logic [NumRegs-1:0]     busyVec
);

   localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

   rf_wr_t          fifo_head;
   logic [CntW-1:0] fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_push;
   logic            grant_wb;
   logic            grant_fifo;
   logic            starved;
   logic            wb_req;

   logic [StarveW-1:0]     starve_q, starve_d;
   logic [NumRegs-1:0]     busy_q, busy_d;
   logic                   reg_write_enable_q, reg_write_enable_d;
   logic [RegNumWidth-1:0] reg_write_num_q, reg_write_num_d;
   logic [DataWidth-1:0]   reg_write_data_q, reg_write_data_d;

   // MDU results to x0 complete the handshake but are never buffered
   assign mduReady  = (fifo_count < CntW'(FIFO_DEPTH));
   assign fifo_push = mduValid && !fifo_full && (mduNum != '0);
   assign wb_req    = wbValid && (wbNum != '0);
   assign starved   = (starve_q == StarveW'(STARVE_LIMIT)) && !fifo_empty;

   regarb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry ('{num: mduNum, data: mduData}),
      .pop        (grant_fifo),
      .head       (fifo_head),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Port arbitration: starved FIFO head, then WB, then FIFO head
   always_comb begin
      grant_wb   = 1'b0;
      grant_fifo = 1'b0;
      wbStall    = 1'b0;
      if (starved) begin
         grant_fifo = 1'b1;
         wbStall    = 1'b1;
      end else if (wb_req) begin
         grant_wb = 1'b1;
      end else if (!fifo_empty) begin
         grant_fifo = 1'b1;
      end
   end

   // Starvation counter, next write-port value and scoreboard update
   always_comb begin
      starve_d           = starve_q;
      busy_d             = busy_q;
      reg_write_enable_d = grant_wb || grant_fifo;
      reg_write_num_d    = reg_write_num_q;
      reg_write_data_d   = reg_write_data_q;

      if (fifo_empty || grant_fifo) begin
         starve_d = '0;
      end else if (grant_wb && (starve_q < StarveW'(STARVE_LIMIT))) begin
         starve_d = starve_q + StarveW'(1);
      end

      if (grant_fifo) begin
         reg_write_num_d  = fifo_head.num;
         reg_write_data_d = fifo_head.data;
      end else if (grant_wb) begin
         reg_write_num_d  = wbNum;
         reg_write_data_d = wbData;
      end

      // Set after clear so a same-cycle issue to the same register wins
      if (grant_fifo) begin
         busy_d[fifo_head.num] = 1'b0;
      end
      if (mduIssue && (mduIssueNum != '0)) begin
         busy_d[mduIssueNum] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Hazards follow the scoreboard's next value so they drop in the grant cycle
   assign hazard0        = busy_d[regNum0];
   assign hazard1        = busy_d[regNum1];
   assign busyVec        = busy_q;
   assign regWriteEnable = reg_write_enable_q;
   assign regWriteNum    = reg_write_num_q;
   assign regWriteData   = reg_write_data_q;

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q           <= '0;
         busy_q             <= '0;
         reg_write_enable_q <= 1'b0;
         reg_write_num_q    <= '0;
         reg_write_data_q   <= '0;
      end else begin
         starve_q           <= starve_d;
         busy_q             <= busy_d;
         reg_write_enable_q <= reg_write_enable_d;
         reg_write_num_q    <= reg_write_num_d;
         reg_write_data_q   <= reg_write_data_d;
      end
   end

`ifdef REGARB_TRACE_EN
   logic src_q, src_d;

   // Remember which side produced the write now on the port
   always_comb begin
      src_d = grant_fifo ? SRC_MDU : SRC_WB;
   end

   // Source tag register, aligned with the write-port registers
   always_ff @(posedge clk) begin
      if (reset) begin
         src_q <= SRC_WB;
      end else begin
         src_q <= src_d;
      end
   end

   // Trace each committed write and each forced WB stall
   always_ff @(posedge clk) begin
      if (!reset && reg_write_enable_q) begin
         $display("regarb: src=%s x%0d = %h", (src_q == SRC_MDU) ? "MDU" : "WB",
                  reg_write_num_q, reg_write_data_q);
      end
      if (!reset && wbStall) begin
         $display("regarb: starve");
      end
   end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a per-cycle vector table covering
// MDU latency, WB/MDU contention, starvation, backpressure, x0 handling and
// mid-operation reset, plus a hand-written starvation/order sequence.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wbValid;
   logic [4:0]  wbNum;
   logic [31:0] wbData;
   logic        wbStall;
   logic        mduIssue;
   logic [4:0]  mduIssueNum;
   logic        mduValid;
   logic        mduReady;
   logic [4:0]  mduNum;
   logic [31:0] mduData;
   logic [4:0]  regNum0;
   logic [4:0]  regNum1;
   logic        hazard0;
   logic        hazard1;
   logic        regWriteEnable;
   logic [4:0]  regWriteNum;
   logic [31:0] regWriteData;
   logic [31:0] busyVec;

   int checks;
   int failures;
   int cur_row;

   typedef struct packed {
      logic        rst;
      logic        wv;
      logic [4:0]  wn;
      logic [31:0] wd;
      logic        iss;
      logic [4:0]  in;
      logic        mv;
      logic [4:0]  mn;
      logic [31:0] md;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic        e_stall;
      logic        e_rdy;
      logic        e_h0;
      logic        e_h1;
      logic        e_we;
      logic [4:0]  e_num;
      logic [31:0] e_data;
      logic [31:0] e_busy;
   } vec_t;

   localparam int NV = 32;
   vec_t vt [NV];

   logic [4:0]  got_num  [16];
   logic [31:0] got_data [16];
   logic [4:0]  exp_num  [9];
   logic [31:0] exp_data [9];
   int n_got, wb_sent, stall_cnt, haz_cnt;

   always #5 clk = ~clk;

   regfile_write_arbiter #(
      .FIFO_DEPTH   (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .wbValid        (wbValid),
      .wbNum          (wbNum),
      .wbData         (wbData),
      .wbStall        (wbStall),
      .mduIssue       (mduIssue),
      .mduIssueNum    (mduIssueNum),
      .mduValid       (mduValid),
      .mduReady       (mduReady),
      .mduNum         (mduNum),
      .mduData        (mduData),
      .regNum0        (regNum0),
      .regNum1        (regNum1),
      .hazard0        (hazard0),
      .hazard1        (hazard1),
      .regWriteEnable (regWriteEnable),
      .regWriteNum    (regWriteNum),
      .regWriteData   (regWriteData),
      .busyVec        (busyVec)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%h required=%h", name, cur_row, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wbValid     = 1'b0;
      wbNum       = 5'd0;
      wbData      = 32'h0;
      mduIssue    = 1'b0;
      mduIssueNum = 5'd0;
      mduValid    = 1'b0;
      mduNum      = 5'd0;
      mduData     = 32'h0;
   endtask

   task automatic drive(input vec_t v);
      reset       = v.rst;
      wbValid     = v.wv;
      wbNum       = v.wn;
      wbData      = v.wd;
      mduIssue    = v.iss;
      mduIssueNum = v.in;
      mduValid    = v.mv;
      mduNum      = v.mn;
      mduData     = v.md;
      regNum0     = v.r0;
      regNum1     = v.r1;
   endtask

   task automatic compare(input vec_t v);
      chk("wbStall",        32'(wbStall),        32'(v.e_stall));
      chk("mduReady",       32'(mduReady),       32'(v.e_rdy));
      chk("hazard0",        32'(hazard0),        32'(v.e_h0));
      chk("hazard1",        32'(hazard1),        32'(v.e_h1));
      chk("regWriteEnable", 32'(regWriteEnable), 32'(v.e_we));
      chk("regWriteNum",    32'(regWriteNum),    32'(v.e_num));
      chk("regWriteData",   regWriteData,        v.e_data);
      chk("busyVec",        busyVec,             v.e_busy);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog row=%0d actual=timeout required=finish", cur_row);
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      cur_row  = -1;
      //            rst  wv   wn     wd            iss  in     mv   mn     md            r0     r1     st   rdy  h0   h1   we   num    data          busy
      // MDU result latency and hazard window on x5
      vt[0]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd5, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0,    32'h0};
      vt[1]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b1,5'd5, 32'h1234,     5'd5, 5'd9, 1'b0,1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0,    32'h20};
      vt[2]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,    32'h20};
      vt[3]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd5, 32'h1234, 32'h0};
      // WB x3 and FIFO x7 contend: WB first
      vt[4]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd7, 1'b1,5'd7, 32'hBB,       5'd5, 5'd7, 1'b0,1'b1,1'b0,1'b1,1'b0,5'd5, 32'h1234, 32'h0};
      vt[5]  = '{1'b0,1'b1,5'd3, 32'hAA,       1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd7, 1'b0,1'b1,1'b0,1'b1,1'b0,5'd5, 32'h1234, 32'h80};
      vt[6]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd7, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd3, 32'hAA,   32'h80};
      vt[7]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd7, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd7, 32'hBB,   32'h0};
      // Starvation: FIFO x9 forced through on the 5th WB cycle
      vt[8]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd9, 1'b1,5'd9, 32'hC9,       5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b1,1'b0,5'd7, 32'hBB,   32'h0};
      vt[9]  = '{1'b0,1'b1,5'd1, 32'h11,       1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b1,1'b0,5'd7, 32'hBB,   32'h200};
      vt[10] = '{1'b0,1'b1,5'd2, 32'h22,       1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b1,1'b1,5'd1, 32'h11,   32'h200};
      vt[11] = '{1'b0,1'b1,5'd3, 32'h33,       1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b1,1'b1,5'd2, 32'h22,   32'h200};
      vt[12] = '{1'b0,1'b1,5'd4, 32'h44,       1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b1,1'b1,5'd3, 32'h33,   32'h200};
      vt[13] = '{1'b0,1'b1,5'd5, 32'h55,       1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b1,1'b1,1'b0,1'b0,1'b1,5'd4, 32'h44,   32'h200};
      vt[14] = '{1'b0,1'b1,5'd5, 32'h55,       1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd9, 32'hC9,   32'h0};
      vt[15] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd5, 32'h55,   32'h0};
      // Backpressure: third result held until a pop frees a slot
      vt[16] = '{1'b0,1'b1,5'd1, 32'h01,       1'b0,5'd0, 1'b1,5'd10,32'hA0,       5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd5, 32'h55,   32'h0};
      vt[17] = '{1'b0,1'b1,5'd2, 32'h02,       1'b0,5'd0, 1'b1,5'd11,32'hB1,       5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd1, 32'h01,   32'h0};
      vt[18] = '{1'b0,1'b1,5'd3, 32'h03,       1'b0,5'd0, 1'b1,5'd12,32'hC2,       5'd5, 5'd9, 1'b0,1'b0,1'b0,1'b0,1'b1,5'd2, 32'h02,   32'h0};
      vt[19] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b1,5'd12,32'hC2,       5'd5, 5'd9, 1'b0,1'b0,1'b0,1'b0,1'b1,5'd3, 32'h03,   32'h0};
      vt[20] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b1,5'd12,32'hC2,       5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd10,32'hA0,   32'h0};
      vt[21] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd11,32'hB1,   32'h0};
      vt[22] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b1,5'd12,32'hC2,   32'h0};
      // x0 from both sides: no write, no buffering, no busy bit
      vt[23] = '{1'b0,1'b1,5'd0, 32'hBEEF,     1'b1,5'd0, 1'b1,5'd0, 32'hDEAD,     5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd12,32'hC2,   32'h0};
      vt[24] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd12,32'hC2,   32'h0};
      vt[25] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd12,32'hC2,   32'h0};
      // Reset with two buffered results and x5/x9 busy
      vt[26] = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd5, 1'b1,5'd5, 32'h55AA,     5'd5, 5'd9, 1'b0,1'b1,1'b1,1'b0,1'b0,5'd12,32'hC2,   32'h0};
      vt[27] = '{1'b0,1'b1,5'd1, 32'h01,       1'b1,5'd9, 1'b1,5'd9, 32'h99,       5'd5, 5'd9, 1'b0,1'b1,1'b1,1'b1,1'b0,5'd12,32'hC2,   32'h20};
      vt[28] = '{1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,5'd1, 32'h01,   32'h220};
      vt[29] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,    32'h0};
      vt[30] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,    32'h0};
      vt[31] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 32'h0,        5'd5, 5'd9, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,    32'h0};

      // Expected write order for the hand-written starvation sequence
      for (int k = 0; k < 9; k++) begin
         if (k < 4) begin
            exp_num[k]  = 5'(k + 1);
            exp_data[k] = 32'h100 + 32'(k + 1);
         end else if (k == 4) begin
            exp_num[k]  = 5'd20;
            exp_data[k] = 32'h2020;
         end else begin
            exp_num[k]  = 5'(k);
            exp_data[k] = 32'h100 + 32'(k);
         end
      end

      reset = 1'b1;
      idle_inputs();
      regNum0 = 5'd5;
      regNum1 = 5'd9;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_busyVec",  busyVec,                32'h0);
      chk("rst_we",       32'(regWriteEnable),    32'h0);
      chk("rst_num",      32'(regWriteNum),       32'h0);
      chk("rst_data",     regWriteData,           32'h0);
      chk("rst_wbStall",  32'(wbStall),           32'h0);
      chk("rst_mduReady", 32'(mduReady),          32'h1);
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         cur_row = i;
         drive(vt[i]);
         #1;
         compare(vt[i]);
         @(posedge clk);
         #1;
      end

      // Hand sequence: x20 buffered while WB streams 8 writes, one held by wbStall
      cur_row   = 100;
      reset     = 1'b0;
      n_got     = 0;
      wb_sent   = 0;
      stall_cnt = 0;
      haz_cnt   = 0;
      for (int c = 0; c < 20; c++) begin
         idle_inputs();
         regNum0 = 5'd20;
         regNum1 = 5'd0;
         if (c == 0) begin
            mduIssue    = 1'b1;
            mduIssueNum = 5'd20;
            mduValid    = 1'b1;
            mduNum      = 5'd20;
            mduData     = 32'h2020;
         end else if (wb_sent < 8) begin
            wbValid = 1'b1;
            wbNum   = 5'(wb_sent + 1);
            wbData  = 32'h100 + 32'(wb_sent + 1);
         end
         #1;
         if (hazard0) haz_cnt++;
         if (wbStall) stall_cnt++;
         if (regWriteEnable && n_got < 16) begin
            got_num[n_got]  = regWriteNum;
            got_data[n_got] = regWriteData;
            n_got++;
         end
         if (wbValid && !wbStall) wb_sent++;
         @(posedge clk);
         #1;
      end
      chk("seq_wb_sent",    32'(wb_sent),   32'd8);
      chk("seq_writes",     32'(n_got),     32'd9);
      chk("seq_stalls",     32'(stall_cnt), 32'd1);
      chk("seq_hazard_cyc", 32'(haz_cnt),   32'd5);
      for (int k = 0; k < 9; k++) begin
         cur_row = 200 + k;
         chk("seq_order_num",  32'(got_num[k]), 32'(exp_num[k]));
         chk("seq_order_data", got_data[k],     exp_data[k]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
